// File: rtl/id_ex_stage_fwd_pkg.sv
// Shared pipeline definitions for the ID/EX stage: forwarding encodings,
// control-bundle layout and default datapath widths.
package id_ex_stage_fwd_pkg;

    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned DEF_REG_AW = 5;
    localparam int unsigned DEF_CNT_W  = 16;
    localparam int unsigned FUNCT_W    = 10;

    // Control bundle: {RegWrite, MemtoReg, MemRead, MemWrite, ALUSrc, ALUOp[1:0]}
    localparam int unsigned CTRL_W          = 7;
    localparam int unsigned CTRL_REG_WRITE  = 6;
    localparam int unsigned CTRL_MEM_TO_REG = 5;
    localparam int unsigned CTRL_MEM_READ   = 4;
    localparam int unsigned CTRL_MEM_WRITE  = 3;
    localparam int unsigned CTRL_ALU_SRC    = 2;
    localparam int unsigned CTRL_ALU_OP_HI  = 1;
    localparam int unsigned CTRL_ALU_OP_LO  = 0;

    typedef enum logic [1:0] {
        FWD_EX  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

    typedef struct packed {
        logic       reg_write;
        logic       mem_to_reg;
        logic       mem_read;
        logic       mem_write;
        logic       alu_src;
        logic [1:0] alu_op;
    } ctrl_t;

endpackage

// File: rtl/id_ex_stage_fwd_if.sv
// ID/EX stage bus: ID-side operands and control, hazard inputs from MEM/WB,
// and the registered EX-side view including the forwarding selects.
interface id_ex_stage_fwd_if
    import id_ex_stage_fwd_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned REG_AW = DEF_REG_AW,
    parameter int unsigned CNT_W  = DEF_CNT_W
);
    logic                stall_i;
    logic                flush_i;
    logic [DATA_W-1:0]   RS1data_i;
    logic [DATA_W-1:0]   RS2data_i;
    logic [DATA_W-1:0]   imm_i;
    logic [REG_AW-1:0]   RS1addr_i;
    logic [REG_AW-1:0]   RS2addr_i;
    logic [REG_AW-1:0]   RDaddr_i;
    logic [FUNCT_W-1:0]  funct_i;
    logic                RegWrite_i;
    logic                MemtoReg_i;
    logic                MemRead_i;
    logic                MemWrite_i;
    logic                ALUSrc_i;
    logic [1:0]          ALUOp_i;
    logic [REG_AW-1:0]   EXMEM_RDaddr_i;
    logic                EXMEM_RegWrite_i;
    logic [REG_AW-1:0]   MEMWB_RDaddr_i;
    logic                MEMWB_RegWrite_i;

    logic [DATA_W-1:0]   RS1data_o;
    logic [DATA_W-1:0]   RS2data_o;
    logic [DATA_W-1:0]   imm_o;
    logic [REG_AW-1:0]   RS1addr_o;
    logic [REG_AW-1:0]   RS2addr_o;
    logic [REG_AW-1:0]   RDaddr_o;
    logic [FUNCT_W-1:0]  funct_o;
    logic                RegWrite_o;
    logic                MemtoReg_o;
    logic                MemRead_o;
    logic                MemWrite_o;
    logic                ALUSrc_o;
    logic [1:0]          ALUOp_o;
    logic                valid_o;
    logic [1:0]          ForwardA_o;
    logic [1:0]          ForwardB_o;
    logic [CNT_W-1:0]    bubble_cnt_o;

    modport slave (
        input  stall_i, flush_i, RS1data_i, RS2data_i, imm_i,
               RS1addr_i, RS2addr_i, RDaddr_i, funct_i,
               RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i, ALUSrc_i, ALUOp_i,
               EXMEM_RDaddr_i, EXMEM_RegWrite_i, MEMWB_RDaddr_i, MEMWB_RegWrite_i,
        output RS1data_o, RS2data_o, imm_o, RS1addr_o, RS2addr_o, RDaddr_o, funct_o,
               RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o, ALUSrc_o, ALUOp_o,
               valid_o, ForwardA_o, ForwardB_o, bubble_cnt_o
    );

    modport master (
        output stall_i, flush_i, RS1data_i, RS2data_i, imm_i,
               RS1addr_i, RS2addr_i, RDaddr_i, funct_i,
               RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i, ALUSrc_i, ALUOp_i,
               EXMEM_RDaddr_i, EXMEM_RegWrite_i, MEMWB_RDaddr_i, MEMWB_RegWrite_i,
        input  RS1data_o, RS2data_o, imm_o, RS1addr_o, RS2addr_o, RDaddr_o, funct_o,
               RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o, ALUSrc_o, ALUOp_o,
               valid_o, ForwardA_o, ForwardB_o, bubble_cnt_o
    );

endinterface

// File: rtl/id_ex_stage_fwd_fwd_select.sv
// Forwarding select for one EX source operand: MEM result beats WB result,
// and x0 is never forwarded.
module id_ex_stage_fwd_fwd_select
    import id_ex_stage_fwd_pkg::*;
#(
    parameter int unsigned REG_AW = DEF_REG_AW
) (
    input  logic [REG_AW-1:0] rs_addr,
    input  logic [REG_AW-1:0] exmem_rd_addr,
    input  logic              exmem_reg_write,
    input  logic [REG_AW-1:0] memwb_rd_addr,
    input  logic              memwb_reg_write,
    output fwd_sel_e          fwd_sel_c
);

    always_comb begin
        fwd_sel_c = FWD_EX;
        if (exmem_reg_write && (exmem_rd_addr != '0) && (exmem_rd_addr == rs_addr)) begin
            fwd_sel_c = FWD_MEM;
        end else if (memwb_reg_write && (memwb_rd_addr != '0) && (memwb_rd_addr == rs_addr)) begin
            fwd_sel_c = FWD_WB;
        end
    end

endmodule

// File: rtl/id_ex_stage_fwd.sv
// ID/EX pipeline register with stall/flush handling, a saturating bubble
// counter, and the ForwardA/ForwardB selects for the EX operand muxes.
module id_ex_stage_fwd
    import id_ex_stage_fwd_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned REG_AW = DEF_REG_AW,
    parameter int unsigned CNT_W  = DEF_CNT_W
) (
    input logic               clk_i,
    input logic               rst_i,
    id_ex_stage_fwd_if.slave  bus
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [DATA_W-1:0]  rs1_data_q;
    logic [DATA_W-1:0]  rs2_data_q;
    logic [DATA_W-1:0]  imm_q;
    logic [REG_AW-1:0]  rs1_addr_q;
    logic [REG_AW-1:0]  rs2_addr_q;
    logic [REG_AW-1:0]  rd_addr_q;
    logic [FUNCT_W-1:0] funct_q;
    ctrl_t              ctrl_d;
    ctrl_t              ctrl_q;
    logic               valid_q;
    logic [CNT_W-1:0]   bubble_cnt_q;
    fwd_sel_e           fwd_a_c;
    fwd_sel_e           fwd_b_c;

    // Gather ID control bits into the bundle
    always_comb begin
        ctrl_d            = '0;
        ctrl_d.reg_write  = bus.RegWrite_i;
        ctrl_d.mem_to_reg = bus.MemtoReg_i;
        ctrl_d.mem_read   = bus.MemRead_i;
        ctrl_d.mem_write  = bus.MemWrite_i;
        ctrl_d.alu_src    = bus.ALUSrc_i;
        ctrl_d.alu_op     = bus.ALUOp_i;
    end

    // Stage register: reset > flush (bubble) > stall (hold) > load
    always_ff @(posedge clk_i) begin
        if (rst_i || bus.flush_i) begin
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            imm_q      <= '0;
            rs1_addr_q <= '0;
            rs2_addr_q <= '0;
            rd_addr_q  <= '0;
            funct_q    <= '0;
            ctrl_q     <= '0;
            valid_q    <= 1'b0;
        end else if (!bus.stall_i) begin
            rs1_data_q <= bus.RS1data_i;
            rs2_data_q <= bus.RS2data_i;
            imm_q      <= bus.imm_i;
            rs1_addr_q <= bus.RS1addr_i;
            rs2_addr_q <= bus.RS2addr_i;
            rd_addr_q  <= bus.RDaddr_i;
            funct_q    <= bus.funct_i;
            ctrl_q     <= ctrl_d;
            valid_q    <= 1'b1;
        end
    end

    // Saturating count of inserted bubbles
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bubble_cnt_q <= '0;
        end else if (bus.flush_i && (bubble_cnt_q != CNT_MAX)) begin
            bubble_cnt_q <= bubble_cnt_q + CNT_W'(1);
        end
    end

    id_ex_stage_fwd_fwd_select #(.REG_AW(REG_AW)) u_fwd_a (
        .rs_addr         (rs1_addr_q),
        .exmem_rd_addr   (bus.EXMEM_RDaddr_i),
        .exmem_reg_write (bus.EXMEM_RegWrite_i),
        .memwb_rd_addr   (bus.MEMWB_RDaddr_i),
        .memwb_reg_write (bus.MEMWB_RegWrite_i),
        .fwd_sel_c       (fwd_a_c)
    );

    id_ex_stage_fwd_fwd_select #(.REG_AW(REG_AW)) u_fwd_b (
        .rs_addr         (rs2_addr_q),
        .exmem_rd_addr   (bus.EXMEM_RDaddr_i),
        .exmem_reg_write (bus.EXMEM_RegWrite_i),
        .memwb_rd_addr   (bus.MEMWB_RDaddr_i),
        .memwb_reg_write (bus.MEMWB_RegWrite_i),
        .fwd_sel_c       (fwd_b_c)
    );

    assign bus.RS1data_o    = rs1_data_q;
    assign bus.RS2data_o    = rs2_data_q;
    assign bus.imm_o        = imm_q;
    assign bus.RS1addr_o    = rs1_addr_q;
    assign bus.RS2addr_o    = rs2_addr_q;
    assign bus.RDaddr_o     = rd_addr_q;
    assign bus.funct_o      = funct_q;
    assign bus.RegWrite_o   = ctrl_q.reg_write;
    assign bus.MemtoReg_o   = ctrl_q.mem_to_reg;
    assign bus.MemRead_o    = ctrl_q.mem_read;
    assign bus.MemWrite_o   = ctrl_q.mem_write;
    assign bus.ALUSrc_o     = ctrl_q.alu_src;
    assign bus.ALUOp_o      = ctrl_q.alu_op;
    assign bus.valid_o      = valid_q;
    assign bus.ForwardA_o   = fwd_a_c;
    assign bus.ForwardB_o   = fwd_b_c;
    assign bus.bubble_cnt_o = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_stage_fwd.sv
// Self-checking bench for id_ex_stage_fwd: directed hazard/stall/flush steps,
// a randomized phase against a cycle-level reference model, and counter saturation.
module tb_id_ex_stage_fwd;

    localparam int DATA_W  = 32;
    localparam int REG_AW  = 5;
    localparam int CNT_W   = 16;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    id_ex_stage_fwd_if #(.DATA_W(DATA_W), .REG_AW(REG_AW), .CNT_W(CNT_W)) bus ();

    id_ex_stage_fwd #(.DATA_W(DATA_W), .REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected EX-stage contents
    typedef struct packed {
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic [4:0]  rd;
        logic [9:0]  funct;
        logic        rw;
        logic        mtr;
        logic        mr;
        logic        mw;
        logic        as;
        logic [1:0]  op;
        logic        valid;
    } ex_t;

    ex_t m;
    int  m_cnt;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] exp_fwd(input logic [4:0] addr);
        if (bus.EXMEM_RegWrite_i && bus.EXMEM_RDaddr_i != 0 && bus.EXMEM_RDaddr_i == addr) return 2'b10;
        if (bus.MEMWB_RegWrite_i && bus.MEMWB_RDaddr_i != 0 && bus.MEMWB_RDaddr_i == addr) return 2'b01;
        return 2'b00;
    endfunction

    // Apply one clock edge to the model using the inputs held across that edge
    task automatic model_step();
        if (rst) begin
            m     = '0;
            m_cnt = 0;
        end else if (bus.flush_i) begin
            m     = '0;
            m_cnt = (m_cnt + 1 > CNT_MAX) ? CNT_MAX : m_cnt + 1;
        end else if (!bus.stall_i) begin
            m.rs1   = bus.RS1data_i;
            m.rs2   = bus.RS2data_i;
            m.imm   = bus.imm_i;
            m.a1    = bus.RS1addr_i;
            m.a2    = bus.RS2addr_i;
            m.rd    = bus.RDaddr_i;
            m.funct = bus.funct_i;
            m.rw    = bus.RegWrite_i;
            m.mtr   = bus.MemtoReg_i;
            m.mr    = bus.MemRead_i;
            m.mw    = bus.MemWrite_i;
            m.as    = bus.ALUSrc_i;
            m.op    = bus.ALUOp_i;
            m.valid = 1'b1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic check_fwd(input string tag);
        check({tag, ":fwdA"}, 64'(bus.ForwardA_o), 64'(exp_fwd(m.a1)));
        check({tag, ":fwdB"}, 64'(bus.ForwardB_o), 64'(exp_fwd(m.a2)));
    endtask

    task automatic check_all(input string tag);
        check({tag, ":rs1d"},  64'(bus.RS1data_o),    64'(m.rs1));
        check({tag, ":rs2d"},  64'(bus.RS2data_o),    64'(m.rs2));
        check({tag, ":imm"},   64'(bus.imm_o),        64'(m.imm));
        check({tag, ":rs1a"},  64'(bus.RS1addr_o),    64'(m.a1));
        check({tag, ":rs2a"},  64'(bus.RS2addr_o),    64'(m.a2));
        check({tag, ":rda"},   64'(bus.RDaddr_o),     64'(m.rd));
        check({tag, ":funct"}, 64'(bus.funct_o),      64'(m.funct));
        check({tag, ":ctrl"},  64'({bus.RegWrite_o, bus.MemtoReg_o, bus.MemRead_o,
                                     bus.MemWrite_o, bus.ALUSrc_o, bus.ALUOp_o}),
                               64'({m.rw, m.mtr, m.mr, m.mw, m.as, m.op}));
        check({tag, ":valid"}, 64'(bus.valid_o),      64'(m.valid));
        check({tag, ":cnt"},   64'(bus.bubble_cnt_o), 64'(m_cnt));
        check_fwd(tag);
    endtask

    task automatic rand_id();
        bus.RS1data_i  = $urandom;
        bus.RS2data_i  = $urandom;
        bus.imm_i      = $urandom;
        bus.RS1addr_i  = 5'($urandom_range(0, 7));
        bus.RS2addr_i  = 5'($urandom_range(0, 7));
        bus.RDaddr_i   = 5'($urandom_range(0, 31));
        bus.funct_i    = 10'($urandom);
        bus.RegWrite_i = 1'($urandom_range(0, 1));
        bus.MemtoReg_i = 1'($urandom_range(0, 1));
        bus.MemRead_i  = 1'($urandom_range(0, 1));
        bus.MemWrite_i = 1'($urandom_range(0, 1));
        bus.ALUSrc_i   = 1'($urandom_range(0, 1));
        bus.ALUOp_i    = 2'($urandom_range(0, 3));
    endtask

    task automatic rand_hazard();
        bus.EXMEM_RDaddr_i   = 5'($urandom_range(0, 7));
        bus.EXMEM_RegWrite_i = 1'($urandom_range(0, 1));
        bus.MEMWB_RDaddr_i   = 5'($urandom_range(0, 7));
        bus.MEMWB_RegWrite_i = 1'($urandom_range(0, 1));
    endtask

    initial begin
        errors = 0;
        checks = 0;
        m      = '0;
        m_cnt  = 0;

        // Reset with nonzero inputs everywhere
        rst         = 1'b1;
        bus.stall_i = 1'b0;
        bus.flush_i = 1'b0;
        rand_id();
        bus.RS1addr_i        = 5'd3;
        bus.EXMEM_RDaddr_i   = 5'd3;
        bus.EXMEM_RegWrite_i = 1'b1;
        bus.MEMWB_RDaddr_i   = 5'd4;
        bus.MEMWB_RegWrite_i = 1'b1;
        tick();
        tick();
        check_all("reset");
        check("reset:rs1d_zero", 64'(bus.RS1data_o), 64'h0);
        check("reset:valid0",    64'(bus.valid_o), 64'h0);
        check("reset:fwdA00",    64'(bus.ForwardA_o), 64'h0);
        check("reset:cnt0",      64'(bus.bubble_cnt_o), 64'h0);

        // Load, then EX/MEM hazard on rs1
        rst = 1'b0;
        rand_id();
        bus.RS1addr_i  = 5'd5;
        bus.RS2addr_i  = 5'd6;
        bus.RS1data_i  = 32'h11;
        bus.RegWrite_i = 1'b1;
        bus.EXMEM_RegWrite_i = 1'b0;
        bus.MEMWB_RegWrite_i = 1'b0;
        tick();
        check_all("load");
        check("load:rs1d", 64'(bus.RS1data_o), 64'h11);
        check("load:valid", 64'(bus.valid_o), 64'h1);
        check("load:rw", 64'(bus.RegWrite_o), 64'h1);
        bus.EXMEM_RDaddr_i   = 5'd5;
        bus.EXMEM_RegWrite_i = 1'b1;
        #1;
        check("exmem:fwdA", 64'(bus.ForwardA_o), 64'h2);
        check("exmem:fwdB", 64'(bus.ForwardB_o), 64'h0);

        // Double hazard on rs2: MEM wins, then WB
        bus.EXMEM_RDaddr_i   = 5'd6;
        bus.MEMWB_RDaddr_i   = 5'd6;
        bus.MEMWB_RegWrite_i = 1'b1;
        #1;
        check("dbl:fwdB_mem", 64'(bus.ForwardB_o), 64'h2);
        bus.EXMEM_RegWrite_i = 1'b0;
        #1;
        check("dbl:fwdB_wb", 64'(bus.ForwardB_o), 64'h1);
        check("dbl:fwdA", 64'(bus.ForwardA_o), 64'h0);

        // x0 never forwarded; RegWrite=0 never forwarded
        bus.RS1addr_i = 5'd0;
        bus.RS2addr_i = 5'd6;
        tick();
        bus.EXMEM_RDaddr_i   = 5'd0;
        bus.EXMEM_RegWrite_i = 1'b1;
        bus.MEMWB_RDaddr_i   = 5'd6;
        bus.MEMWB_RegWrite_i = 1'b0;
        #1;
        check("x0:fwdA", 64'(bus.ForwardA_o), 64'h0);
        check("rw0:fwdB", 64'(bus.ForwardB_o), 64'h0);
        check_all("x0");

        // Stall three cycles with changing ID inputs
        bus.stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rand_id();
            tick();
            check_all("stall");
            check("stall:rs2a", 64'(bus.RS2addr_o), 64'd6);
            check("stall:cnt", 64'(bus.bubble_cnt_o), 64'd0);
        end
        bus.MEMWB_RegWrite_i = 1'b1;
        #1;
        check("stall:fwdB_live", 64'(bus.ForwardB_o), 64'h1);

        // Flush wins over stall
        bus.flush_i          = 1'b1;
        bus.EXMEM_RDaddr_i   = 5'd6;
        bus.EXMEM_RegWrite_i = 1'b1;
        tick();
        bus.flush_i = 1'b0;
        bus.stall_i = 1'b0;
        check_all("flush");
        check("flush:rw", 64'(bus.RegWrite_o), 64'h0);
        check("flush:valid", 64'(bus.valid_o), 64'h0);
        check("flush:fwdB", 64'(bus.ForwardB_o), 64'h0);
        check("flush:cnt", 64'(bus.bubble_cnt_o), 64'h1);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            rst         = ($urandom_range(0, 49) == 0);
            bus.stall_i = ($urandom_range(0, 3) == 0);
            bus.flush_i = ($urandom_range(0, 5) == 0);
            rand_id();
            rand_hazard();
            tick();
            check_all("rand");
            rand_hazard();
            #1;
            check_fwd("rand_live");
        end

        // Counter saturation
        rst         = 1'b1;
        bus.stall_i = 1'b0;
        bus.flush_i = 1'b0;
        tick();
        rst         = 1'b0;
        bus.flush_i = 1'b1;
        repeat (CNT_MAX) tick();
        check("sat:reach", 64'(bus.bubble_cnt_o), 64'hFFFF);
        tick();
        check("sat:hold", 64'(bus.bubble_cnt_o), 64'hFFFF);
        check_all("sat");
        bus.flush_i = 1'b0;
        tick();
        check("sat:after", 64'(bus.bubble_cnt_o), 64'hFFFF);
        check("sat:valid", 64'(bus.valid_o), 64'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
